// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the parameterised synchronous FIFO.
package sync_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_DEPTH      = 8;

  // Occupancy needs one bit more than the address so that DEPTH itself is representable.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for param_sync_fifo: one synchronous write port, one asynchronous read port.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with occupancy flags, status pulses and a high-water mark.
// Define FIFO_FWFT_EN for first-word fall-through output; default is a registered read.
module param_sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int AF_LEVEL   = DEPTH - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        wr_en,
  input  logic [DATA_WIDTH-1:0]       data_in,
  input  logic                        rd_en,
  output logic [DATA_WIDTH-1:0]       data_out,
  output logic                        rd_valid,
  output logic                        wr_ack,
  output logic                        overflow,
  output logic                        underflow,
  output logic                        full,
  output logic                        empty,
  output logic                        almostfull,
  output logic                        almostempty,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic [cnt_width(DEPTH)-1:0] max_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("param_sync_fifo: DEPTH must be a power of two and at least 4");
  end
  if (AE_LEVEL >= AF_LEVEL) begin : g_bad_ae
    $error("param_sync_fifo: AE_LEVEL must be below AF_LEVEL");
  end
  if (AF_LEVEL > DEPTH) begin : g_bad_af
    $error("param_sync_fifo: AF_LEVEL must not exceed DEPTH");
  end
  if (DATA_WIDTH < 1) begin : g_bad_width
    $error("param_sync_fifo: DATA_WIDTH must be at least 1");
  end

  // Occupancy update, clamped to [0, DEPTH].
  function automatic logic [CW-1:0] sat_count(input logic [CW-1:0] cur,
                                              input logic inc, input logic dec);
    if (inc && !dec) return (cur == CW'(DEPTH)) ? cur : cur + CW'(1);
    if (dec && !inc) return (cur == '0) ? cur : cur - CW'(1);
    return cur;
  endfunction

  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  wr_ok;
  logic                  rd_ok;
  logic [CW-1:0]         count_nxt;

  assign full        = (count == CW'(DEPTH));
  assign empty       = (count == '0);
  assign almostfull  = (count >= CW'(AF_LEVEL));
  assign almostempty = (count <= CW'(AE_LEVEL));

  assign wr_ok     = wr_en && !full;
  assign rd_ok     = rd_en && !empty;
  assign count_nxt = sat_count(count, wr_ok, rd_ok);

  sync_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_mem (
    .clk    (clk),
    .wr_en  (wr_ok && !rst && !clr),
    .wr_addr(wr_ptr),
    .wr_data(data_in),
    .rd_addr(rd_ptr),
    .rd_data(mem_rd_data)
  );

  // Stage p0 -> p1: pointers, occupancy and status pulses
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      max_count <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      if (count_nxt > max_count) max_count <= count_nxt;
      wr_ack    <= wr_ok;
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
    end
  end

`ifdef FIFO_FWFT_EN
  assign data_out = mem_rd_data;
  assign rd_valid = !empty;
`else
  logic [DATA_WIDTH-1:0] rd_data_p1;
  logic                  vld_p1;

  // Stage p0 -> p1: registered read data; data holds through clr
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      rd_data_p1 <= '0;
    end else if (clr) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= rd_ok;
      if (rd_ok) rd_data_p1 <= mem_rd_data;
    end
  end

  assign data_out = rd_data_p1;
  assign rd_valid = vld_p1;
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed self-checking bench for param_sync_fifo at default parameters (16 x 8).
module tb_param_sync_fifo;

  logic        clk = 1'b0;
  logic        rst, clr, wr_en, rd_en;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        rd_valid, wr_ack, overflow, underflow;
  logic        full, empty, almostfull, almostempty;
  logic [3:0]  count, max_count;

  int total = 0;
  int bad   = 0;

  param_sync_fifo dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .wr_en      (wr_en),
    .data_in    (data_in),
    .rd_en      (rd_en),
    .data_out   (data_out),
    .rd_valid   (rd_valid),
    .wr_ack     (wr_ack),
    .overflow   (overflow),
    .underflow  (underflow),
    .full       (full),
    .empty      (empty),
    .almostfull (almostfull),
    .almostempty(almostempty),
    .count      (count),
    .max_count  (max_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    total++; if (count !== 4'd0) begin bad++; $display("FAIL %s_count got=%0d want=0", tag, count); end
    total++; if (max_count !== 4'd0) begin bad++; $display("FAIL %s_max got=%0d want=0", tag, max_count); end
    total++; if (empty !== 1'b1 || almostempty !== 1'b1) begin bad++; $display("FAIL %s_empty got=%b/%b want=1/1", tag, empty, almostempty); end
    total++; if (full !== 1'b0 || almostfull !== 1'b0) begin bad++; $display("FAIL %s_full got=%b/%b want=0/0", tag, full, almostfull); end
    total++; if ({wr_ack, overflow, underflow} !== 3'b000) begin bad++; $display("FAIL %s_pulses got=%b want=000", tag, {wr_ack, overflow, underflow}); end
`ifndef FIFO_FWFT_EN
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL %s_rd_valid got=%b want=0", tag, rd_valid); end
    total++; if (data_out !== 16'h0000) begin bad++; $display("FAIL %s_data_out got=%h want=0000", tag, data_out); end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
    step(); step();
    rst = 1'b0;
    check_reset_state("reset");
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1'b1; data_in = 16'(i);
      step();
      total++; if (wr_ack !== 1'b1) begin bad++; $display("FAIL fill_wr_ack[%0d] got=%b want=1", i, wr_ack); end
      total++; if (count !== 4'(i)) begin bad++; $display("FAIL fill_count[%0d] got=%0d want=%0d", i, count, i); end
      total++; if (almostfull !== (i >= 7)) begin bad++; $display("FAIL fill_af[%0d] got=%b want=%b", i, almostfull, i >= 7); end
      total++; if (almostempty !== (i <= 1)) begin bad++; $display("FAIL fill_ae[%0d] got=%b want=%b", i, almostempty, i <= 1); end
      total++; if (full !== (i == 8)) begin bad++; $display("FAIL fill_full[%0d] got=%b want=%b", i, full, i == 8); end
    end
    data_in = 16'h0009;
    step();
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_pulse got=%b want=1", overflow); end
    total++; if (wr_ack !== 1'b0) begin bad++; $display("FAIL ovf_wr_ack got=%b want=0", wr_ack); end
    total++; if (count !== 4'd8) begin bad++; $display("FAIL ovf_count got=%0d want=8", count); end
    wr_en = 1'b0;
    step();
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want=0", overflow); end
    total++; if (max_count !== 4'd8) begin bad++; $display("FAIL fill_max got=%0d want=8", max_count); end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 8; i++) begin
      rd_en = 1'b1;
`ifdef FIFO_FWFT_EN
      total++; if (data_out !== 16'(i) || rd_valid !== 1'b1) begin bad++; $display("FAIL drain_data[%0d] got=%h/%b want=%h/1", i, data_out, rd_valid, 16'(i)); end
      step();
`else
      step();
      total++; if (data_out !== 16'(i) || rd_valid !== 1'b1) begin bad++; $display("FAIL drain_data[%0d] got=%h/%b want=%h/1", i, data_out, rd_valid, 16'(i)); end
`endif
      total++; if (count !== 4'(8 - i)) begin bad++; $display("FAIL drain_count[%0d] got=%0d want=%0d", i, count, 8 - i); end
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b want=1", empty); end
    step();
    total++; if (underflow !== 1'b1 || empty !== 1'b1) begin bad++; $display("FAIL udf_pulse got=%b/%b want=1/1", underflow, empty); end
`ifndef FIFO_FWFT_EN
    total++; if (rd_valid !== 1'b0 || data_out !== 16'h0008) begin bad++; $display("FAIL udf_hold got=%b/%h want=0/0008", rd_valid, data_out); end
`endif
    rd_en = 1'b0;
    step();
    total++; if (underflow !== 1'b0) begin bad++; $display("FAIL udf_clear got=%b want=0", underflow); end
    total++; if (max_count !== 4'd8) begin bad++; $display("FAIL drain_max got=%0d want=8", max_count); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; data_in = 16'h0100 + 16'(i);
      step();
    end
    for (int k = 0; k < 20; k++) begin
      exp = (k < 3) ? 16'h0100 + 16'(k) : 16'h0200 + 16'(k - 3);
      wr_en = 1'b1; rd_en = 1'b1; data_in = 16'h0200 + 16'(k);
`ifdef FIFO_FWFT_EN
      total++; if (data_out !== exp) begin bad++; $display("FAIL wrap_data[%0d] got=%h want=%h", k, data_out, exp); end
      step();
`else
      step();
      total++; if (data_out !== exp || rd_valid !== 1'b1) begin bad++; $display("FAIL wrap_data[%0d] got=%h/%b want=%h/1", k, data_out, rd_valid, exp); end
`endif
      total++; if (count !== 4'd3) begin bad++; $display("FAIL wrap_count[%0d] got=%0d want=3", k, count); end
    end
    wr_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp = 16'h0200 + 16'(17 + i);
`ifdef FIFO_FWFT_EN
      total++; if (data_out !== exp) begin bad++; $display("FAIL wrap_tail[%0d] got=%h want=%h", i, data_out, exp); end
      step();
`else
      step();
      total++; if (data_out !== exp) begin bad++; $display("FAIL wrap_tail[%0d] got=%h want=%h", i, data_out, exp); end
`endif
    end
    rd_en = 1'b0;
    step();
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL wrap_empty got=%b want=1", empty); end
  endtask

  task automatic test_full_empty_both();
    wr_en = 1'b1; rd_en = 1'b1; data_in = 16'h0055;
    step();
    total++; if (count !== 4'd1) begin bad++; $display("FAIL emptyboth_count got=%0d want=1", count); end
    total++; if (underflow !== 1'b1 || wr_ack !== 1'b1) begin bad++; $display("FAIL emptyboth_pulses got=%b/%b want=1/1", underflow, wr_ack); end
`ifndef FIFO_FWFT_EN
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL emptyboth_rd_valid got=%b want=0", rd_valid); end
`endif
    rd_en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      data_in = 16'h0056 + 16'(i);
      step();
    end
    total++; if (full !== 1'b1) begin bad++; $display("FAIL fullboth_setup got=%b want=1", full); end
    rd_en = 1'b1; data_in = 16'h00EE;
`ifdef FIFO_FWFT_EN
    total++; if (data_out !== 16'h0055) begin bad++; $display("FAIL fullboth_data got=%h want=0055", data_out); end
    step();
`else
    step();
    total++; if (data_out !== 16'h0055 || rd_valid !== 1'b1) begin bad++; $display("FAIL fullboth_data got=%h/%b want=0055/1", data_out, rd_valid); end
`endif
    total++; if (count !== 4'd7) begin bad++; $display("FAIL fullboth_count got=%0d want=7", count); end
    total++; if (overflow !== 1'b1 || wr_ack !== 1'b0) begin bad++; $display("FAIL fullboth_pulses got=%b/%b want=1/0", overflow, wr_ack); end
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_clr_rst();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; data_in = 16'h0061 + 16'(i);
      step();
    end
    total++; if (count !== 4'd6 || max_count !== 4'd6) begin bad++; $display("FAIL clr_setup got=%0d/%0d want=6/6", count, max_count); end
    clr = 1'b1;
    step();
    clr = 1'b0; wr_en = 1'b0;
    total++; if (count !== 4'd0 || max_count !== 4'd0) begin bad++; $display("FAIL clr_counts got=%0d/%0d want=0/0", count, max_count); end
    total++; if (empty !== 1'b1 || wr_ack !== 1'b0 || rd_valid !== 1'b0) begin bad++; $display("FAIL clr_flags got=%b/%b/%b want=1/0/0", empty, wr_ack, rd_valid); end
    wr_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      data_in = 16'h0071 + 16'(i);
      step();
    end
    data_in = 16'h0073; rst = 1'b1;
    step();
    rst = 1'b0; wr_en = 1'b0;
    check_reset_state("rstmid");
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    total++; if (underflow !== 1'b1 || count !== 4'd0) begin bad++; $display("FAIL rstmid_discard got=%b/%0d want=1/0", underflow, count); end
  endtask

  task automatic test_write_visibility();
    wr_en = 1'b1; data_in = 16'hABCD;
    step();
    wr_en = 1'b0;
`ifdef FIFO_FWFT_EN
    total++; if (data_out !== 16'hABCD || rd_valid !== 1'b1) begin bad++; $display("FAIL fwft_head got=%h/%b want=abcd/1", data_out, rd_valid); end
`else
    total++; if (data_out !== 16'h0000 || rd_valid !== 1'b0) begin bad++; $display("FAIL std_nopop got=%h/%b want=0000/0", data_out, rd_valid); end
`endif
    total++; if (count !== 4'd1 || wr_ack !== 1'b1) begin bad++; $display("FAIL vis_count got=%0d/%b want=1/1", count, wr_ack); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_full_empty_both();
    test_clr_rst();
    test_write_visibility();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 8, word count; power of two, >=4.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-1, count at or above which almostfull asserts.
REQ-004 SHALL have parameter AE_LEVEL, default 1, count at or below which almostempty asserts.
REQ-005 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port clr  in  1  synchronous flush; empties FIFO, clears high-water mark.
REQ-008 SHALL have port wr_en  in  1  write request.
REQ-009 SHALL have port data_in  in  DATA_WIDTH  write data.
REQ-010 SHALL have port rd_en  in  1  read request.
REQ-011 SHALL have port data_out  out  DATA_WIDTH  read data.
REQ-012 SHALL have port rd_valid  out  1  data_out holds a valid popped word.
REQ-013 SHALL have ports wr_ack, overflow, underflow  out  1 each  registered per-cycle status pulses.
REQ-014 SHALL have ports full, empty, almostfull, almostempty  out  1 each  occupancy flags.
REQ-015 SHALL have port count  out  $clog2(DEPTH)+1  current occupancy.
REQ-016 SHALL have port max_count  out  $clog2(DEPTH)+1  high-water mark since last rst/clr.

Function
REQ-017 Write accepted when wr_en && (!full || read accepted this cycle is irrelevant): i.e. wr_en && !full; stores data_in at wr_ptr, wr_ptr+1 mod DEPTH.
REQ-018 Read accepted when rd_en && !empty; rd_ptr+1 mod DEPTH.
REQ-019 Full with wr_en&&rd_en: read accepted, write rejected, count-1, overflow=1 next cycle.
REQ-020 Empty with wr_en&&rd_en: write accepted, read rejected, count+1, underflow=1 next cycle.
REQ-021 Neither full nor empty with both enables: both accepted, count unchanged.
REQ-022 wr_ack=1 the cycle after an accepted write, else 0; overflow=1 the cycle after wr_en&&full, else 0; underflow=1 the cycle after rd_en&&empty, else 0.
REQ-023 full=(count==DEPTH), empty=(count==0), almostfull=(count>=AF_LEVEL), almostempty=(count<=AE_LEVEL), combinational from registered count.
REQ-024 count SHALL never exceed DEPTH nor go below 0; pointers wrap silently.
REQ-025 max_count updates to count's next value whenever that exceeds current max_count.
REQ-026 clr (rst low) SHALL zero pointers, count, max_count, rd_valid and status pulses next cycle; enables in the clr cycle are ignored; memory contents untouched.
REQ-027 Standard mode: data_out/rd_valid registered 1 cycle after accepted read; rd_valid=0 after non-accepted cycles; data_out holds last value.

Reset
REQ-028 rst SHALL have priority over clr and all traffic.
REQ-029 After rst: count=0, max_count=0, empty=1, almostempty=1, full=0, almostfull=0, wr_ack=overflow=underflow=0, rd_valid=0, data_out=0.
REQ-030 rst asserted mid-operation SHALL discard all stored words; no memory reset required.

Configuration
REQ-031 Macro FIFO_FWFT_EN, defined: first-word fall-through; data_out=mem[rd_ptr] and rd_valid=!empty combinationally; rd_en pops head with zero latency.
REQ-032 Macro undefined: standard mode per REQ-027; all other requirements identical in both modes.

Structure
REQ-033 Package sync_fifo_pkg SHALL hold default width/depth constants and a function returning count width for a given DEPTH.
REQ-034 Storage SHALL be sub-module sync_fifo_mem (1 write port, 1 read port, DATA_WIDTH x DEPTH); control, flags, counters in param_sync_fifo.
REQ-035 Elaboration SHALL fail if DEPTH not power of two, AE_LEVEL>=AF_LEVEL, or AF_LEVEL>DEPTH.

Verification
REQ-036 Defaults: write 0x0001..0x0008 -> full=1 after 8th, wr_ack 8 pulses; 9th write -> overflow=1 one cycle, count stays 8.
REQ-037 Read 8 words -> data_out 0x0001..0x0008 in order, rd_valid per word; 9th read -> underflow=1, empty=1.
REQ-038 count=3, wr_en=rd_en=1 for 20 cycles -> count stays 3, data order preserved across pointer wrap.
REQ-039 Full + both enables -> count 7, overflow=1; empty + both enables -> count 1, underflow=1, rd_valid=0.
REQ-040 Fill to 6, clr one cycle -> count=0, max_count=0, empty=1; then rst mid-write -> all REQ-029 values.
REQ-041 FIFO_FWFT_EN defined: write 0xABCD to empty FIFO -> data_out=0xABCD, rd_valid=1 the cycle after write, before any rd_en.
